// File: rtl/axi_slave_write_channel.sv
// AXI3 slave write path: accepts one AW burst and its W beats, drives a registered byte-strobed
// memory write port and returns one B response. Define AXI_WSLV_ERRCNT_EN to add err_count.
module axi_slave_write_channel #(
    parameter int WIDTH  = 32,
    parameter int SIZE   = 3,
    parameter int MEM_AW = 12
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               AWVALID,
    output logic               AWREADY,
    input  logic [WIDTH/8-1:0] AWID,
    input  logic [WIDTH-1:0]   AWADDR,
    input  logic [WIDTH/8-1:0] AWLEN,
    input  logic [SIZE-1:0]    AWSIZE,
    input  logic [SIZE-2:0]    AWBURST,
    input  logic               WVALID,
    output logic               WREADY,
    input  logic [WIDTH/8-1:0] WID,
    input  logic [WIDTH-1:0]   WDATA,
    input  logic [WIDTH/8-1:0] WSTRB,
    input  logic               WLAST,
    output logic               BVALID,
    input  logic               BREADY,
    output logic [WIDTH/8-1:0] BID,
    output logic [SIZE-2:0]    BRESP,
`ifdef AXI_WSLV_ERRCNT_EN
    output logic [15:0]        err_count,
`endif
    output logic               mem_wr_en,
    output logic [MEM_AW-1:0]  mem_wr_addr,
    output logic [WIDTH-1:0]   mem_wr_data,
    output logic [WIDTH/8-1:0] mem_wr_strb
);
    // state | meaning
    // IDLE  | waiting for an AW handshake
    // DATA  | accepting W beats of the latched burst
    // RESP  | B response held until BREADY
    localparam int IDW = WIDTH / 8;
    localparam int BW  = SIZE - 1;
    localparam int LW  = $clog2(WIDTH / 8);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
    state_t state_q, state_d;

    logic [IDW-1:0]    id_q, len_q, cnt_q, lane_mask;
    logic [MEM_AW-1:0] addr_q, next_addr, nbytes, aligned, incr_addr, wlen, wrap_addr;
    logic [SIZE-1:0]   size_q;
    logic [BW-1:0]     burst_q, resp_q;
    logic              decerr_q, slverr_q, nowr_q;
    logic              aw_hs, w_hs, b_hs, end_beat, beat_err, aw_nowr;
    logic [LW-1:0]     off;
    int                eff;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        case (state_q)
            IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) state_d = DATA;
            end
            DATA: begin
                WREADY = 1'b1;
                if (WVALID && (WLAST || cnt_q == len_q)) state_d = RESP;
            end
            RESP: begin
                BVALID = 1'b1;
                if (BREADY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign aw_hs    = AWVALID && AWREADY;
    assign w_hs     = WVALID && WREADY;
    assign b_hs     = BVALID && BREADY;
    assign end_beat = WLAST || (cnt_q == len_q);
    assign beat_err = (WID != id_q) || (WLAST != (cnt_q == len_q));
    assign aw_nowr  = (AWBURST == BW'(3)) ||
                      ((AWBURST == BW'(2)) && !(AWLEN == IDW'(1) || AWLEN == IDW'(3) ||
                                               AWLEN == IDW'(7) || AWLEN == IDW'(15)));
    assign BID   = id_q;
    assign BRESP = resp_q;
    assign off   = addr_q[LW-1:0];

    always_comb begin
        nbytes    = MEM_AW'(1) << size_q;
        aligned   = addr_q & ~(nbytes - 1'b1);
        incr_addr = aligned + nbytes;
        wlen      = MEM_AW'({1'b0, len_q} + 1'b1) << size_q;
        wrap_addr = (addr_q & ~(wlen - 1'b1)) | (incr_addr & (wlen - 1'b1));
        case (burst_q)
            BW'(1):  next_addr = incr_addr;
            BW'(2):  next_addr = wrap_addr;
            default: next_addr = addr_q;
        endcase
    end

    // Beats wider than the bus are clamped to the lanes from the beat address up to the word end.
    always_comb begin
        lane_mask = '0;
        eff = (size_q > SIZE'(LW)) ? LW : int'(size_q);
        for (int i = 0; i < IDW; i++)
            if (i >= int'(off) && (i >> eff) == (int'(off) >> eff)) lane_mask[i] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            cnt_q       <= '0;
            decerr_q    <= 1'b0;
            slverr_q    <= 1'b0;
            nowr_q      <= 1'b0;
            resp_q      <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_wr_strb <= '0;
        end else begin
            mem_wr_en <= 1'b0;
            if (aw_hs) begin
                id_q     <= AWID;
                addr_q   <= AWADDR[MEM_AW-1:0];
                len_q    <= AWLEN;
                size_q   <= AWSIZE;
                burst_q  <= AWBURST;
                cnt_q    <= '0;
                decerr_q <= |AWADDR[WIDTH-1:MEM_AW];
                nowr_q   <= aw_nowr;
                slverr_q <= aw_nowr || (AWSIZE > SIZE'(LW));
            end
            if (w_hs) begin
                cnt_q       <= cnt_q + 1'b1;
                addr_q      <= next_addr;
                slverr_q    <= slverr_q || beat_err;
                mem_wr_en   <= !(decerr_q || nowr_q);
                mem_wr_addr <= {addr_q[MEM_AW-1:LW], {LW{1'b0}}};
                mem_wr_data <= WDATA;
                mem_wr_strb <= WSTRB & lane_mask;
                if (end_beat)
                    resp_q <= decerr_q ? BW'(3) : ((slverr_q || beat_err) ? BW'(2) : BW'(0));
            end
        end
    end

`ifdef AXI_WSLV_ERRCNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                              err_count <= '0;
        else if (b_hs && resp_q != BW'(0) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
`else
    logic unused_b_hs;
    assign unused_b_hs = b_hs;
`endif

endmodule

// File: doc/axi_slave_write_channel.md
Name: axi_slave_write_channel

Overview:
- AXI3 slave-side write path: consumes the write address (AW) and write data (W) channels and produces the write response (B) channel.
- Translates accepted beats into a byte-strobed write port on the 4096-byte slave memory.
- Sits directly downstream of the master write-issue logic inside the top design; one outstanding write burst at a time.

Parameters:
- WIDTH, 32, data and address width; ID and LEN fields are WIDTH/8 bits wide.
- SIZE, 3, AWSIZE width; AWBURST and BRESP are SIZE-1 bits wide.
- MEM_AW, 12, memory byte-address width (4096 bytes).

Ports:
- clk  input  1  single clock
- resetn  input  1  asynchronous active-low reset
- AWVALID  input  1  address valid
- AWREADY  output  1  address ready
- AWID  input  WIDTH/8  transaction ID
- AWADDR  input  WIDTH  start byte address
- AWLEN  input  WIDTH/8  beats minus one
- AWSIZE  input  SIZE  log2 bytes per beat
- AWBURST  input  SIZE-1  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- WVALID  input  1  data valid
- WREADY  output  1  data ready
- WID  input  WIDTH/8  data ID
- WDATA  input  WIDTH  data
- WSTRB  input  WIDTH/8  byte strobes
- WLAST  input  1  last beat
- BVALID  output  1  response valid
- BREADY  input  1  response ready
- BID  output  WIDTH/8  response ID
- BRESP  output  SIZE-1  00 OKAY, 10 SLVERR, 11 DECERR
- mem_wr_en  output  1  memory write strobe
- mem_wr_addr  output  MEM_AW  word-aligned byte address
- mem_wr_data  output  WIDTH  write data
- mem_wr_strb  output  WIDTH/8  byte enables

Behaviour:
- Reset is asynchronous on resetn low. All outputs go to 0, except AWREADY, which goes to 1. The FSM enters IDLE. Reset during a burst abandons it: no B response and no further memory writes.
- FSM states are IDLE, DATA and RESP.
- IDLE: AWREADY=1, WREADY=0, BVALID=0.
  - On AWVALID&AWREADY, latch ID, ADDR, LEN, SIZE and BURST, clear the beat counter and error flags, then go to DATA. WREADY rises on the next cycle.
- DATA: AWREADY=0, WREADY=1.
  - Each WVALID&WREADY beat increments the beat counter.
  - The beat ends the burst when WLAST=1 or counter==LEN; the next cycle is RESP with BVALID=1.
- RESP: BVALID=1, and BID/BRESP are held stable until BREADY. On BVALID&BREADY, go to IDLE, where AWREADY=1 on the next cycle.
- Memory write is registered. A handshake beat in cycle N drives mem_wr_en=1 in cycle N+1, unless the burst is flagged DECERR or has a reserved/illegal burst type.
  - mem_wr_addr = beat address with the low log2(WIDTH/8) bits cleared.
  - mem_wr_strb = WSTRB AND the lane mask of the beat's (1<<SIZE) bytes at the beat address.
- Address update per beat:
  - FIXED: address unchanged.
  - INCR: address = aligned address + (1<<SIZE). No 4KB-boundary handling; the address wraps modulo 2^MEM_AW.
  - WRAP: wrap boundary = (LEN+1)*(1<<SIZE). The address wraps to the lower boundary on reaching the upper one.
- Error priority is DECERR over SLVERR over OKAY.
  - DECERR: AWADDR bits above MEM_AW are non-zero. No memory writes.
  - SLVERR: any of the following, with writes suppressed only for the last two:
    - WLAST arrives before counter==LEN.
    - counter==LEN is reached without WLAST.
    - Any beat has WID != latched ID.
    - AWSIZE > log2(WIDTH/8).
    - BURST=11.
    - WRAP with LEN not in {1,3,7,15}.
- An errored burst still consumes all its beats and gets exactly one response.
- W beats presented in IDLE are not accepted; WREADY stays 0.

Optional Feature:
- Macro AXI_WSLV_ERRCNT_EN.
- When defined: adds output err_count [15:0]. It resets to 0 and increments by 1 on each B handshake with BRESP != OKAY, saturating at 16'hFFFF.
- When undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- INCR, AWADDR=0x100, LEN=3, SIZE=2, WSTRB=F, data 0xA0..0xA3, BREADY=1 -> four mem writes at 0x100/0x104/0x108/0x10C with strb F; BRESP=00 with BID=AWID one cycle after the last beat.
- WRAP, AWADDR=0x108, LEN=3, SIZE=2 -> write addresses 0x108, 0x10C, 0x100, 0x104; BRESP=00.
- FIXED, AWADDR=0x201, SIZE=0, LEN=1, WSTRB=F -> two writes at 0x200 with strb 0x2; BRESP=00.
- AWADDR=0x0000_2000, LEN=0 -> W beat accepted, no mem_wr_en, BRESP=11; with the macro, err_count=1.
- INCR LEN=3 with WLAST on beat 2 -> burst ends after 2 beats (2 writes), BRESP=10; then BREADY held low 5 cycles -> BVALID/BID/BRESP stable, AWREADY=0 until the handshake.
- resetn low mid-DATA (after beat 1 of 4) -> all outputs 0 and AWREADY=1 immediately; no BVALID after release; the next burst completes OKAY.
